// File: rtl/ndma_pkg.sv
// Shared types, defaults and parameter checks for the NanoDMA OBI write path.
package ndma_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Write command as issued by the channel sequencer at the default bus widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
  } ndma_wcmd_t;

  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/ndma_fifo.sv
// Synchronous FIFO with registered occupancy; the head word is read combinationally.
module ndma_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rptr];

  // NOTE: storage is deliberately not reset; count alone says which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ndma_write_mgr_q.sv
// Pipelined OBI write manager: queues write commands, keeps up to MAX_OUTST writes
// in flight and captures the address of the first bus error.
module ndma_write_mgr_q
  import ndma_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_be_i,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [ADDR_W-1:0]   obi_addr_o,
  output logic                obi_we_o,
  output logic [DATA_W/8-1:0] obi_be_o,
  output logic [DATA_W-1:0]   obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic                obi_err_i,
  output logic                idle_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  input  logic                err_clr_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFS_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("ndma_write_mgr_q: DATA_W must be 32 or 64");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } wcmd_t;

  wcmd_t             cmd_in;
  wcmd_t             cmd_head;
  logic              cmd_full;
  logic              cmd_empty;
  logic              grant;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_full_unused;
  logic              rsp_empty_unused;
  logic [CNT_W-1:0]  outst_cnt;

  always_comb begin
    cmd_in.addr  = cmd_addr_i & ALIGN_MASK;
    cmd_in.wdata = cmd_wdata_i;
    cmd_in.be    = cmd_be_i;
  end

  ndma_fifo #(.WIDTH($bits(wcmd_t)), .DEPTH(FIFO_DEPTH)) u_cmd_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .wdata_i (cmd_in),
    .pop_i   (grant),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  // Remembers the address of every granted write so a response can be attributed.
  ndma_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_rsp_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .wdata_i (cmd_head.addr),
    .pop_i   (rsp_valid),
    .rdata_o (rsp_addr),
    .full_o  (rsp_full_unused),
    .empty_o (rsp_empty_unused)
  );

  assign cmd_ready_o = !cmd_full;
  assign obi_req_o   = !cmd_empty && (outst_cnt < CNT_W'(MAX_OUTST));
  assign grant       = obi_req_o && obi_gnt_i;
  assign rsp_valid   = obi_rvalid_i && (outst_cnt != '0);
  assign idle_o      = cmd_empty && (outst_cnt == '0);

  // Head storage is not reset, so the bus fields are forced to zero while the queue is empty.
  assign obi_we_o    = 1'b1;
  assign obi_addr_o  = cmd_empty ? '0 : cmd_head.addr;
  assign obi_wdata_o = cmd_empty ? '0 : cmd_head.wdata;
  assign obi_be_o    = cmd_empty ? '0 : cmd_head.be;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_cnt <= '0;
    end else if (grant && !rsp_valid) begin
      outst_cnt <= outst_cnt + 1'b1;
    end else if (!grant && rsp_valid) begin
      outst_cnt <= outst_cnt - 1'b1;
    end
  end

  // A new error beats a same-cycle clear; otherwise the first captured address sticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (rsp_valid && obi_err_i && (!err_o || err_clr_i)) begin
      err_o      <= 1'b1;
      err_addr_o <= rsp_addr;
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end
  end

endmodule

// File: tb/tb_ndma_write_mgr_q.sv
// Directed bench for ndma_write_mgr_q: grants are checked by a scoreboard monitor,
// control/status behaviour by directed checks in the main sequence.
module tb_ndma_write_mgr_q;

  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic        obi_err;
  logic        idle;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  logic        auto_rsp;
  logic        rvalid_man;
  logic        gnt_last;

  logic        c64_valid;
  logic        c64_ready;
  logic [31:0] c64_addr;
  logic [63:0] c64_wdata;
  logic [7:0]  c64_be;
  logic        req64;
  logic        gnt64;
  logic [31:0] addr64;
  logic        we64;
  logic [7:0]  be64;
  logic [63:0] wdata64;
  logic        rvalid64;
  logic        idle64;
  logic        err64;
  logic [31:0] err_addr64;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign obi_rvalid = auto_rsp ? gnt_last : rvalid_man;

  ndma_write_mgr_q dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_be_i     (cmd_be),
    .obi_req_o    (obi_req),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr),
    .obi_we_o     (obi_we),
    .obi_be_o     (obi_be),
    .obi_wdata_o  (obi_wdata),
    .obi_rvalid_i (obi_rvalid),
    .obi_err_i    (obi_err),
    .idle_o       (idle),
    .err_o        (err),
    .err_addr_o   (err_addr),
    .err_clr_i    (err_clr)
  );

  ndma_write_mgr_q #(.DATA_W(64)) dut64 (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (c64_valid),
    .cmd_ready_o  (c64_ready),
    .cmd_addr_i   (c64_addr),
    .cmd_wdata_i  (c64_wdata),
    .cmd_be_i     (c64_be),
    .obi_req_o    (req64),
    .obi_gnt_i    (gnt64),
    .obi_addr_o   (addr64),
    .obi_we_o     (we64),
    .obi_be_o     (be64),
    .obi_wdata_o  (wdata64),
    .obi_rvalid_i (rvalid64),
    .obi_err_i    (1'b0),
    .idle_o       (idle64),
    .err_o        (err64),
    .err_addr_o   (err_addr64),
    .err_clr_i    (1'b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_be    = b;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = d;
    e.be    = b;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    present(a, d, b);
    expect_write(a, d, b);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (idle) break;
      step();
    end
    check(name, 64'(idle), 64'd1);
  endtask

  // One write with gnt held high, then a single response carrying the given err/clear.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic e, input logic c);
    send(a, d, 4'hF);
    step();
    cmd_valid = 1'b0;
    step();
    rvalid_man = 1'b1;
    obi_err    = e;
    err_clr    = c;
    step();
    rvalid_man = 1'b0;
    obi_err    = 1'b0;
    err_clr    = 1'b0;
  endtask

  initial begin
    gnt_last = 1'b0;
    forever begin
      @(posedge clk);
      gnt_last <= rst_i ? 1'b0 : (obi_req && obi_gnt);
    end
  end

  // Scoreboard monitor: every grant must match the oldest expected write.
  initial begin
    int   model_outst;
    exp_t e;
    model_outst = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        model_outst = 0;
      end else begin
        if (model_outst >= MAX_OUTST) check("limit_req", 64'(obi_req), 64'd0);
        if (obi_req && obi_gnt) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("grant_addr", 64'(obi_addr), 64'(e.addr));
            check("grant_wdata", 64'(obi_wdata), 64'(e.wdata));
            check("grant_be", 64'(obi_be), 64'(e.be));
            check("grant_we", 64'(obi_we), 64'd1);
          end
          model_outst++;
        end
        if (obi_rvalid && model_outst > 0) model_outst--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_be     = '0;
    obi_gnt    = 1'b0;
    obi_err    = 1'b0;
    err_clr    = 1'b0;
    auto_rsp   = 1'b0;
    rvalid_man = 1'b0;
    c64_valid  = 1'b0;
    c64_addr   = '0;
    c64_wdata  = '0;
    c64_be     = '0;
    gnt64      = 1'b0;
    rvalid64   = 1'b0;
    step();
    step();

    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_req", 64'(obi_req), 64'd0);
    check("rst_addr", 64'(obi_addr), 64'd0);
    check("rst_be", 64'(obi_be), 64'd0);
    check("rst_wdata", 64'(obi_wdata), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    rst_i = 1'b0;
    step();

    // Single write, gnt two cycles late.
    send(32'h1000_0003, 32'hDEAD_BEEF, 4'hF);
    step();
    cmd_valid = 1'b0;
    check("single_req_c1", 64'(obi_req), 64'd1);
    check("single_addr_c1", 64'(obi_addr), 64'h1000_0000);
    step();
    check("single_req_c2", 64'(obi_req), 64'd1);
    check("single_addr_c2", 64'(obi_addr), 64'h1000_0000);
    obi_gnt = 1'b1;
    check("single_req_c3", 64'(obi_req), 64'd1);
    check("single_addr_c3", 64'(obi_addr), 64'h1000_0000);
    step();
    obi_gnt = 1'b0;
    check("single_req_after", 64'(obi_req), 64'd0);
    check("single_busy", 64'(idle), 64'd0);
    rvalid_man = 1'b1;
    step();
    rvalid_man = 1'b0;
    check("single_idle", 64'(idle), 64'd1);

    // Back-to-back stream: one grant per cycle, ready never drops.
    obi_gnt  = 1'b1;
    auto_rsp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h0000_0200 + 32'(i * 16) + 32'(i % 4), 32'hA500_0000 + 32'(i), 4'(i * 3));
      check("b2b_ready", 64'(cmd_ready), 64'd1);
      step();
      check("b2b_req", 64'(obi_req), 64'd1);
    end
    cmd_valid = 1'b0;
    wait_idle("b2b_idle");

    // Outstanding limit with responses withheld.
    auto_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'h0000_0300 + 32'(i * 4), 32'h3000_0000 + 32'(i), 4'hF);
      step();
    end
    cmd_valid = 1'b0;
    check("lim_drop", 64'(obi_req), 64'd0);
    step();
    check("lim_hold", 64'(obi_req), 64'd0);
    rvalid_man = 1'b1;
    step();
    rvalid_man = 1'b0;
    check("lim_resume", 64'(obi_req), 64'd1);
    step();
    check("lim_after", 64'(obi_req), 64'd0);
    rvalid_man = 1'b1;
    step();
    step();
    rvalid_man = 1'b0;
    check("lim_idle", 64'(idle), 64'd1);

    // Queue fill with gnt low, then drain in order.
    obi_gnt  = 1'b0;
    auto_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_0400 + 32'(i * 4), 32'h4000_0000 + 32'(i), 4'hF);
      check("fill_ready", 64'(cmd_ready), 64'd1);
      step();
    end
    present(32'h0000_0410, 32'h4000_0004, 4'h5);
    check("fill_full", 64'(cmd_ready), 64'd0);
    step();
    check("fill_stall", 64'(cmd_ready), 64'd0);
    obi_gnt = 1'b1;
    check("fill_pop_no_push", 64'(cmd_ready), 64'd0);
    step();
    check("fill_reopen", 64'(cmd_ready), 64'd1);
    expect_write(32'h0000_0410, 32'h4000_0004, 4'h5);
    step();
    cmd_valid = 1'b0;
    wait_idle("fill_idle");

    // Error capture, sticky address, clear, clear-vs-error priority.
    auto_rsp = 1'b0;
    do_write(32'h10, 32'h5000_0001, 1'b0, 1'b0);
    check("err_none", 64'(err), 64'd0);
    do_write(32'h20, 32'h5000_0002, 1'b1, 1'b0);
    check("err_first", 64'(err), 64'd1);
    check("err_first_addr", 64'(err_addr), 64'h20);
    do_write(32'h30, 32'h5000_0003, 1'b1, 1'b0);
    check("err_sticky_addr", 64'(err_addr), 64'h20);
    do_write(32'h40, 32'h5000_0004, 1'b0, 1'b0);
    check("err_still", 64'(err), 64'd1);
    check("err_traffic_idle", 64'(idle), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_flag", 64'(err), 64'd0);
    check("err_clr_addr", 64'(err_addr), 64'd0);
    do_write(32'h56, 32'h5000_0005, 1'b1, 1'b1);
    check("err_set_prio", 64'(err), 64'd1);
    check("err_set_prio_addr", 64'(err_addr), 64'h54);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Reset with 3 queued and 2 outstanding, then a stray errored response.
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_0600 + 32'(i * 4), 32'h6000_0000 + 32'(i), 4'hF);
      step();
    end
    cmd_valid = 1'b0;
    check("pre_rst_busy", 64'(idle), 64'd0);
    obi_gnt = 1'b0;
    rst_i   = 1'b1;
    exp_q.delete();
    step();
    rst_i = 1'b0;
    check("mid_rst_idle", 64'(idle), 64'd1);
    check("mid_rst_req", 64'(obi_req), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    rvalid_man = 1'b1;
    obi_err    = 1'b1;
    step();
    rvalid_man = 1'b0;
    obi_err    = 1'b0;
    check("stray_err", 64'(err), 64'd0);
    check("stray_idle", 64'(idle), 64'd1);

    // 64-bit data path: 8-byte alignment and be passthrough.
    c64_valid = 1'b1;
    c64_addr  = 32'h107;
    c64_wdata = 64'h0123_4567_89AB_CDEF;
    c64_be    = 8'hF0;
    step();
    c64_valid = 1'b0;
    check("w64_req", 64'(req64), 64'd1);
    check("w64_addr", 64'(addr64), 64'h100);
    check("w64_be", 64'(be64), 64'hF0);
    check("w64_wdata", wdata64, 64'h0123_4567_89AB_CDEF);
    gnt64 = 1'b1;
    step();
    gnt64    = 1'b0;
    rvalid64 = 1'b1;
    step();
    rvalid64 = 1'b0;
    check("w64_idle", 64'(idle64), 64'd1);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
